// File: rtl/sram_mem_controller_if.sv
// MEM-stage request/response and 16-bit SRAM pad signals for sram_mem_controller.
interface sram_mem_controller_if #(
    parameter int unsigned SRAM_AW = 18
) ();
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;

    // Pipeline/pad side: issues requests and returns pad read data.
    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    // Controller side.
    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_controller.sv
// Sequences one 32-bit MEM-stage load/store as two halfword phases on a 16-bit SRAM,
// holding ready low (pipeline freeze) while the access is in flight.
module sram_mem_controller #(
    parameter int unsigned BASE_ADDR    = 1024,
    parameter int unsigned PHASE_CYCLES = 2,
    parameter int unsigned SRAM_AW      = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_mem_controller_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [SRAM_AW-2:0] widx_q, widx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [15:0]        stage_lo_q;
    logic [31:0]        read_data_q;

    logic               request;
    logic               last_cycle;
    logic [31:0]        offset;
    logic [SRAM_AW-2:0] req_widx;
    logic               unused_offset;

    assign request    = bus.rd_en | bus.wr_en;
    assign last_cycle = (cnt_q == 4'(PHASE_CYCLES - 1));

    // Word index wraps modulo the SRAM size; out-of-range addresses are not flagged.
    assign offset        = bus.address - 32'(BASE_ADDR);
    assign req_widx      = offset[SRAM_AW:2];
    assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

    // State, phase counter and latched request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic; both enables together count as a write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (request) begin
                    op_wr_d = bus.wr_en;
                    widx_d  = req_widx;
                    wdata_d = bus.write_data;
                    state_d = StLow;
                end
            end
            StLow: begin
                if (last_cycle) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHigh: begin
                if (last_cycle) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Load capture: low half staged at end of LOW, full word published at end of HIGH
    // so it is visible throughout DONE and held until the next load completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_lo_q  <= '0;
            read_data_q <= '0;
        end else if (!op_wr_q && last_cycle) begin
            if (state_q == StLow) begin
                stage_lo_q <= bus.sram_dq_in;
            end else if (state_q == StHigh) begin
                read_data_q <= {bus.sram_dq_in, stage_lo_q};
            end
        end
    end

    // Pad and handshake outputs decoded from registered state; only ready sees the request.
    always_comb begin
        bus.ready       = 1'b1;
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        unique case (state_q)
            StIdle: bus.ready = ~request;
            StLow: begin
                bus.ready       = 1'b0;
                bus.sram_addr   = {widx_q, 1'b0};
                bus.sram_dq_oe  = op_wr_q;
                bus.sram_dq_out = op_wr_q ? wdata_q[15:0] : 16'h0;
                // Release we_n one cycle early so addr/data are stable at its rising edge.
                bus.sram_we_n   = ~(op_wr_q & ~last_cycle);
            end
            StHigh: begin
                bus.ready       = 1'b0;
                bus.sram_addr   = {widx_q, 1'b1};
                bus.sram_dq_oe  = op_wr_q;
                bus.sram_dq_out = op_wr_q ? wdata_q[31:16] : 16'h0;
                bus.sram_we_n   = ~(op_wr_q & ~last_cycle);
            end
            StDone: bus.ready = 1'b1;
            default: bus.ready = 1'b1;
        endcase
        if (!rst) begin
            bus.ready = 1'b1;
        end
    end

    assign bus.read_data = read_data_q;
endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: table vectors, hand-written reset sequences and random
// loads/stores checked against a word-level memory model.
module tb_sram_mem_controller;
    localparam int PC = 2;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        int          drop;
        logic [31:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    logic [15:0] sram [0:262143];
    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] last_read = 32'h0;
    vec_t        vecs [10];

    sram_mem_controller_if #(.SRAM_AW(18)) bus ();

    sram_mem_controller #(
        .BASE_ADDR(1024),
        .PHASE_CYCLES(PC),
        .SRAM_AW(18)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: asynchronous read, write on a clock edge while we_n is low.
    assign bus.sram_dq_in = sram[bus.sram_addr];
    always @(posedge clk) begin
        if (!bus.sram_we_n && bus.sram_dq_oe) sram[bus.sram_addr] <= bus.sram_dq_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, 32'(bus.sram_addr), 32'h0);
        check({tag, "_oe"}, 32'(bus.sram_dq_oe), 32'h0);
        check({tag, "_we_n"}, 32'(bus.sram_we_n), 32'h1);
        check({tag, "_dq_out"}, 32'(bus.sram_dq_out), 32'h0);
        check({tag, "_ready"}, 32'(bus.ready), 32'h1);
    endtask

    // One complete access starting in IDLE; returns at DONE (+1) with inputs released.
    task automatic run_op(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data, input int drop);
        logic        is_wr;
        logic        high;
        logic        done;
        logic [31:0] off;
        logic [16:0] widx;
        logic [15:0] exp_half;
        int          stall;
        int          p;
        int          pos;
        is_wr = wr;
        off   = addr - 32'd1024;
        widx  = off[18:2];
        stall = 0;
        done  = 1'b0;
        @(negedge clk);
        bus.rd_en = rd;
        bus.wr_en = wr;
        bus.address = addr;
        bus.write_data = data;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.ready) begin
                done = 1'b1;
                break;
            end
            stall++;
            if (stall >= 2) begin
                p    = stall - 2;
                high = (p >= PC);
                pos  = high ? p - PC : p;
                exp_half = high ? data[31:16] : data[15:0];
                check("phase_addr", 32'(bus.sram_addr), 32'({widx, high}));
                check("phase_oe", 32'(bus.sram_dq_oe), 32'(is_wr));
                if (is_wr) check("phase_dq_out", 32'(bus.sram_dq_out), 32'(exp_half));
                check("phase_we_n", 32'(bus.sram_we_n), 32'(!(is_wr && pos != PC - 1)));
            end
            if (drop != 0 && stall == drop) begin
                bus.rd_en = 1'b0;
                bus.wr_en = 1'b0;
            end
            @(negedge clk);
        end
        check("done_reached", 32'(done), 32'h1);
        check("stall_cycles", 32'(stall), 32'(1 + 2 * PC));
        if (is_wr) ref_mem[widx] = data;
        else last_read = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
        check("read_data", bus.read_data, last_read);
        check("done_addr", 32'(bus.sram_addr), 32'h0);
        check("done_we_n", 32'(bus.sram_we_n), 32'h1);
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          sel;
        int          drop;

        for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
        vecs[0] = '{1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'd1032, 32'h0,       0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'd1024, 32'h12345678, 0, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'h0,       0, 32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 0, 32'h12345678};
        vecs[5] = '{1'b0, 1'b1, 32'd1036, 32'h0,       0, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 32'd1040, 32'hA5A55A5A, 2, 32'hCAFEF00D};
        vecs[7] = '{1'b0, 1'b1, 32'd1040, 32'h0,       3, 32'hA5A55A5A};
        vecs[8] = '{1'b1, 1'b0, 32'd1020, 32'h0BADF00D, 0, 32'hA5A55A5A};
        vecs[9] = '{1'b0, 1'b1, 32'd1020, 32'h0,       0, 32'h0BADF00D};

        // Reset with a pending store: ready must still read 1.
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b1;
        bus.address = 32'd1032;
        bus.write_data = 32'h11112222;
        #3;
        check_idle_outputs("reset0");
        check("reset0_read_data", bus.read_data, 32'h0);
        bus.wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_ready", 32'(bus.ready), 32'h1);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].drop);
            check("tbl_read_data", bus.read_data, vecs[i].exp_rd);
        end

        // Asynchronous reset mid-store, between clock edges, with wr_en still high.
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.address = 32'd3000;
        bus.write_data = 32'h55AA55AA;
        @(negedge clk);
        #1;
        check("pre_rst_we_n", 32'(bus.sram_we_n), 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check_idle_outputs("rst_store");
        check("rst_store_read_data", bus.read_data, 32'h0);
        last_read = 32'h0;
        bus.wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Load of the wrapped word, then reset during HIGH.
        run_op(1'b0, 1'b1, 32'd1032, 32'h0, 0);
        @(negedge clk);
        bus.rd_en = 1'b1;
        bus.address = 32'd1020;
        repeat (3) @(negedge clk);
        #1;
        check("wrap_high_addr", 32'(bus.sram_addr), 32'h3FFFF);
        check("pre_rst_read_data", bus.read_data, 32'hDEADBEEF);
        rst = 1'b0;
        #1;
        check_idle_outputs("rst_high");
        check("rst_high_read_data", bus.read_data, 32'h0);
        last_read = 32'h0;
        bus.rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, 0);

        // Random traffic over a small pool of words.
        for (int i = 0; i < 40; i++) begin
            a    = 32'd1024 + 32'(4 * $urandom_range(0, 15));
            d    = $urandom;
            sel  = $urandom_range(0, 2);
            drop = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 5) : 0;
            run_op(sel != 0, sel != 1, a, d, drop);
        end

        @(negedge clk);
        #1;
        check_idle_outputs("final_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
